yout_deserializer: RTL and testbench

YOUT_DESERIALIZER -- requirements
Module: yout_deserializer

---
 rtl/yout_deserializer.sv | 100 ++++++++++
 tb/tb_yout_deserializer.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/yout_deserializer.sv
// Serial-to-parallel assembler for the wembley_88 Yout bit stream: collects WORD_W bits
// MSB-first and hands complete words to a consumer through a small ready/valid buffer.
module yout_deserializer #(
    parameter int WORD_W     = 8,
    parameter int FIFO_DEPTH = 2,
    localparam int CNT_W     = $clog2(WORD_W),
    localparam int PTR_W     = $clog2(FIFO_DEPTH),
    localparam int LVL_W     = PTR_W + 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              yin,
    input  logic              sample_en,
    input  logic              flush,
    output logic [WORD_W-1:0] word_out,
    output logic              word_valid,
    input  logic              word_ready,
    output logic [CNT_W-1:0]  bit_cnt,
    output logic [LVL_W-1:0]  fifo_level,
    output logic              overflow,
    input  logic              clr_ovf
);

    logic [WORD_W-1:0] sh;
    logic [WORD_W-1:0] new_word;
    logic [WORD_W-1:0] mem [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic              sample_ok;
    logic              complete;
    logic              full;
    logic              pop;
    logic              push;

    // A flush in the same cycle as a sample discards that sample entirely.
    assign sample_ok  = sample_en && !flush;
    assign new_word   = {sh[WORD_W-2:0], yin};
    assign complete   = sample_ok && (bit_cnt == CNT_W'(WORD_W - 1));
    assign full       = (fifo_level == LVL_W'(FIFO_DEPTH));
    assign word_valid = (fifo_level != '0);
    assign pop        = word_valid && word_ready;
    assign push       = complete && (!full || pop);
    assign word_out   = mem[rd_ptr];

    // NOTE: every clocked block uses non-blocking assignments so that all registers
    // see the pre-edge values of each other, independent of statement order.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sh      <= '0;
            bit_cnt <= '0;
        end else if (flush) begin
            sh      <= '0;
            bit_cnt <= '0;
        end else if (sample_en) begin
            sh <= new_word;
            if (bit_cnt == CNT_W'(WORD_W - 1)) begin
                bit_cnt <= '0;
            end else begin
                bit_cnt <= bit_cnt + CNT_W'(1);
            end
        end
    end

    // Depth is a power of two, so the pointers wrap naturally at their width.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_level <= '0;
            overflow   <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   fifo_level <= fifo_level + LVL_W'(1);
                2'b01:   fifo_level <= fifo_level - LVL_W'(1);
                default: fifo_level <= fifo_level;
            endcase
            // A drop in the same cycle as a clear keeps the flag set.
            if (complete && full && !pop) begin
                overflow <= 1'b1;
            end else if (clr_ovf) begin
                overflow <= 1'b0;
            end
        end
    end

    // NOTE: the word storage has no reset; entries are only read once fifo_level
    // says they were written, so clearing them would add logic for no benefit.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= new_word;
        end
    end

endmodule

// File: tb/tb_yout_deserializer.sv
// Directed bench for yout_deserializer (WORD_W=8, FIFO_DEPTH=2): a vector table for
// the bit-level behaviour plus hand sequences for buffering, overflow and reset.
module tb_yout_deserializer;

    logic       clk;
    logic       reset;
    logic       yin;
    logic       sample_en;
    logic       flush;
    logic [7:0] word_out;
    logic       word_valid;
    logic       word_ready;
    logic [2:0] bit_cnt;
    logic [1:0] fifo_level;
    logic       overflow;
    logic       clr_ovf;

    int checks;
    int failures;

    typedef struct {
        logic       se;
        logic       yin;
        logic       fl;
        logic       rdy;
        logic       ev;
        logic [7:0] ew;
        logic [2:0] ebc;
        logic [1:0] elv;
        logic       eo;
    } vec_t;

    vec_t vecs[$];

    yout_deserializer #(.WORD_W(8), .FIFO_DEPTH(2)) dut (
        .clk        (clk),
        .reset      (reset),
        .yin        (yin),
        .sample_en  (sample_en),
        .flush      (flush),
        .word_out   (word_out),
        .word_valid (word_valid),
        .word_ready (word_ready),
        .bit_cnt    (bit_cnt),
        .fifo_level (fifo_level),
        .overflow   (overflow),
        .clr_ovf    (clr_ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic add(input logic se, input logic y, input logic fl, input logic rdy,
                       input logic ev, input logic [7:0] ew, input logic [2:0] ebc,
                       input logic [1:0] elv, input logic eo);
        vec_t v;
        v.se = se; v.yin = y; v.fl = fl; v.rdy = rdy;
        v.ev = ev; v.ew = ew; v.ebc = ebc; v.elv = elv; v.eo = eo;
        vecs.push_back(v);
    endtask

    // Shifts a word in MSB first; ready/clear can be raised on the completing bit only.
    task automatic send_word(input logic [7:0] w, input logic rdy_last, input logic clr_last);
        for (int i = 7; i >= 0; i--) begin
            yin       = w[i];
            sample_en = 1'b1;
            if (i == 0) begin
                word_ready = rdy_last;
                clr_ovf    = clr_last;
            end
            tick();
        end
        sample_en  = 1'b0;
        word_ready = 1'b0;
        clr_ovf    = 1'b0;
    endtask

    initial begin
        logic [7:0] b2_bits;
        logic [7:0] f_bits;

        checks     = 0;
        failures   = 0;
        reset      = 1'b0;
        yin        = 1'b0;
        sample_en  = 1'b0;
        flush      = 1'b0;
        word_ready = 1'b0;
        clr_ovf    = 1'b0;

        // Reset held with activity on the serial inputs.
        for (int i = 0; i < 4; i++) begin
            yin       = i[0];
            sample_en = ~i[1];
            tick();
            check("rst_valid", word_valid, 0);
            check("rst_bitcnt", bit_cnt, 0);
            check("rst_level", fifo_level, 0);
            check("rst_ovf", overflow, 0);
        end
        sample_en = 1'b0;
        reset     = 1'b1;
        tick();

        // Word B2 streamed with the consumer ready, then one idle cycle.
        b2_bits = 8'hB2;
        for (int k = 1; k <= 7; k++) begin
            add(1, b2_bits[8-k], 0, 1, 0, 8'h00, 3'(k), 2'd0, 0);
        end
        add(1, b2_bits[0], 0, 1, 1, 8'hB2, 3'd0, 2'd1, 0);
        add(0, 1, 0, 1, 0, 8'h00, 3'd0, 2'd0, 0);
        // Five bits, flush, flush colliding with a sample, idle, then word 0F.
        for (int k = 1; k <= 5; k++) begin
            add(1, 1, 0, 1, 0, 8'h00, 3'(k), 2'd0, 0);
        end
        add(0, 1, 1, 1, 0, 8'h00, 3'd0, 2'd0, 0);
        add(1, 1, 1, 1, 0, 8'h00, 3'd0, 2'd0, 0);
        add(0, 1, 0, 1, 0, 8'h00, 3'd0, 2'd0, 0);
        f_bits = 8'h0F;
        for (int k = 1; k <= 7; k++) begin
            add(1, f_bits[8-k], 0, 1, 0, 8'h00, 3'(k), 2'd0, 0);
        end
        add(1, f_bits[0], 0, 1, 1, 8'h0F, 3'd0, 2'd1, 0);
        add(0, 0, 0, 1, 0, 8'h00, 3'd0, 2'd0, 0);

        foreach (vecs[i]) begin
            sample_en  = vecs[i].se;
            yin        = vecs[i].yin;
            flush      = vecs[i].fl;
            word_ready = vecs[i].rdy;
            tick();
            check($sformatf("vec%0d_valid", i), word_valid, vecs[i].ev);
            check($sformatf("vec%0d_bitcnt", i), bit_cnt, vecs[i].ebc);
            check($sformatf("vec%0d_level", i), fifo_level, vecs[i].elv);
            check($sformatf("vec%0d_ovf", i), overflow, vecs[i].eo);
            if (vecs[i].ev) begin
                check($sformatf("vec%0d_word", i), word_out, vecs[i].ew);
            end
        end
        sample_en  = 1'b0;
        flush      = 1'b0;
        word_ready = 1'b0;

        // Consumer stalled: A5, 3C fill the buffer, FF is dropped even with clr_ovf high.
        send_word(8'hA5, 1'b0, 1'b0);
        check("stall_a5_valid", word_valid, 1);
        check("stall_a5_word", word_out, 8'hA5);
        check("stall_a5_level", fifo_level, 1);
        send_word(8'h3C, 1'b0, 1'b0);
        check("stall_3c_level", fifo_level, 2);
        check("stall_3c_word", word_out, 8'hA5);
        check("stall_3c_ovf", overflow, 0);
        send_word(8'hFF, 1'b0, 1'b1);
        check("drop_level", fifo_level, 2);
        check("drop_ovf_setwins", overflow, 1);
        check("drop_head", word_out, 8'hA5);
        word_ready = 1'b1;
        tick();
        check("drain1_word", word_out, 8'h3C);
        check("drain1_level", fifo_level, 1);
        tick();
        check("drain2_valid", word_valid, 0);
        check("drain2_level", fifo_level, 0);
        word_ready = 1'b0;
        tick();
        check("ovf_sticky", overflow, 1);
        clr_ovf = 1'b1;
        tick();
        clr_ovf = 1'b0;
        check("ovf_cleared", overflow, 0);

        // Full buffer, completing word coincides with a pop: both succeed.
        send_word(8'hA5, 1'b0, 1'b0);
        send_word(8'h3C, 1'b0, 1'b0);
        send_word(8'h81, 1'b1, 1'b0);
        check("pushpop_level", fifo_level, 2);
        check("pushpop_ovf", overflow, 0);
        check("pushpop_word", word_out, 8'h3C);
        word_ready = 1'b1;
        tick();
        check("pushpop_next", word_out, 8'h81);
        check("pushpop_lvl1", fifo_level, 1);
        tick();
        check("pushpop_empty", word_valid, 0);
        word_ready = 1'b0;

        // Reset mid-word with one word buffered.
        send_word(8'h5A, 1'b0, 1'b0);
        check("pre_rst_word", word_out, 8'h5A);
        for (int i = 0; i < 3; i++) begin
            yin       = ~i[0];
            sample_en = 1'b1;
            tick();
        end
        sample_en = 1'b0;
        check("pre_rst_bitcnt", bit_cnt, 3);
        #2 reset = 1'b0;
        #1;
        check("async_rst_valid", word_valid, 0);
        check("async_rst_level", fifo_level, 0);
        check("async_rst_bitcnt", bit_cnt, 0);
        #2 reset = 1'b1;
        send_word(8'hC3, 1'b0, 1'b0);
        check("post_rst_level", fifo_level, 1);
        check("post_rst_word", word_out, 8'hC3);
        word_ready = 1'b1;
        tick();
        check("post_rst_empty", word_valid, 0);
        check("post_rst_lvl0", fifo_level, 0);
        word_ready = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
